pwm_timebase: RTL
=================

PWM_TIMEBASE -- requirements
Module: pwm_timebase

Interface
REQ-001 SHALL have parameter CNT_W, default 7: width of TCR, CCR and period.
REQ-002 SHALL have parameter DIV_W, default 8: width of the prescaler divide value.
REQ-003 SHALL have port CLK, input, 1 bit: system clock; all logic on rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port EN, input, 1 bit: timebase run enable.
REQ-006 SHALL have port DIV, input, DIV_W bits: prescaler; one count step every DIV+1 clocks.
REQ-007 SHALL have port PER_IN, input, CNT_W bits: requested period; TCR counts 0..PER.
REQ-008 SHALL have port CCR_IN, input, CNT_W bits: requested compare value.
REQ-009 SHALL have port CCR_WR, input, 1 bit: one-clock strobe capturing CCR_IN.
REQ-010 SHALL have port TCR, output, CNT_W bits: timer count to the PWM output stage.
REQ-011 SHALL have port CCR, output, CNT_W bits: active compare value to the PWM output stage.
REQ-012 SHALL have port E, output, 1 bit: period-start enable to the PWM output stage.
REQ-013 SHALL have port TICK, output, 1 bit: one-clock pulse on each count step.
REQ-014 SHALL have port PEND, output, 1 bit: a written CCR value is waiting for the period boundary.

Function
REQ-015 SHALL hold prescaler counter PSC; when EN=1: PSC>=DIV -> TICK=1, PSC<=0; else PSC<=PSC+1, TICK=0.
REQ-016 SHALL use the >= compare so that lowering DIV mid-count gives a TICK within one clock, never a lockup.
REQ-017 SHALL treat DIV=0 as TICK every clock while EN=1.
REQ-018 SHALL, on TICK: TCR==PER_ACT -> TCR<=0 (wrap); else TCR<=TCR+1.
REQ-019 SHALL load PER_ACT from PER_IN only on wrap, so TCR never exceeds PER_ACT.
REQ-020 SHALL, when EN=0: freeze PSC and TCR; TICK=0; CCR_WR still accepted into the shadow.
REQ-021 SHALL drive E = (TCR==0) as a combinational decode of the TCR register, with no extra latency.
REQ-022 SHALL, on CCR_WR: SHADOW<=CCR_IN, PEND<=1; multiple writes before a wrap: last write wins.
REQ-023 SHALL, on wrap: CCR<=SHADOW if PEND=1, PEND<=0; CCR_WR in the wrap cycle: CCR<=CCR_IN directly, PEND<=0.
REQ-024 SHALL never change CCR except at wrap or reset, giving glitch-free duty updates.
REQ-025 SHALL pass CCR_IN unclamped: CCR=0 gives 0% duty; CCR>PER_ACT gives 100% duty (downstream compare never matches).
REQ-026 SHALL keep all outputs registered except E.

Reset
REQ-027 SHALL, while RST_N=0 at a rising edge, set PSC=0, TCR=0, CCR=0, SHADOW=0, PEND=0, TICK=0, PER_ACT<=PER_IN.
REQ-028 SHALL drive E=1 during and immediately after reset because TCR=0.
REQ-029 SHALL discard any pending CCR on reset applied mid-period; the first TICK after release moves TCR from 0 to 1.

Structure
REQ-030 SHALL take CNT_W, DIV_W defaults and reset constants from shared package pwm_pkg, also used by the PWM output stage.
REQ-031 SHALL contain one sub-module, pwm_prescaler, implementing PSC and TICK (REQ-015..017, REQ-020).
REQ-032 SHALL keep the TCR, PER_ACT and CCR shadow logic in the top of pwm_timebase.

Verification
REQ-033 SHALL cover: DIV=0, PER_IN=9, EN=1 from reset -> TCR 0..9 repeating; E high 1 clock in 10; TICK every clock.
REQ-034 SHALL cover: DIV=3, PER_IN=4 -> TICK every 4th clock; TCR period 20 clocks; EN=0 for 7 clocks freezes TCR and PSC exactly.
REQ-035 SHALL cover: CCR_WR with 3, then CCR_WR with 6 at TCR=2 -> CCR stays 0 until wrap, then 6; PEND high from first write to wrap.
REQ-036 SHALL cover: CCR_WR with 5 in the exact wrap cycle -> CCR=5 on the next clock; PEND stays 0.
REQ-037 SHALL cover: PER_IN 9->4 at TCR=7 -> count continues 8,9,0 and then 0..4; DIV 200->2 at PSC=50 -> TICK the next clock.
REQ-038 SHALL cover: RST_N low for 1 clock at TCR=6 with PEND=1 -> TCR=0, CCR=0, PEND=0; E=1 after reset.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM timebase and the PWM output stage.
package pwm_pkg;

    localparam int CNT_W_DEF = 7;
    localparam int DIV_W_DEF = 8;

    // Reset values for the single-bit flags; vectors reset to all zeros.
    localparam logic TICK_RST = 1'b0;
    localparam logic PEND_RST = 1'b0;

endpackage

// File: rtl/pwm_timebase_if.sv
// Control/status bundle between the PWM controller (master) and the timebase (slave).
interface pwm_timebase_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
);

    logic             EN;
    logic [DIV_W-1:0] DIV;
    logic [CNT_W-1:0] PER_IN;
    logic [CNT_W-1:0] CCR_IN;
    logic             CCR_WR;
    logic [CNT_W-1:0] TCR;
    logic [CNT_W-1:0] CCR;
    logic             E;
    logic             TICK;
    logic             PEND;

    modport master (
        output EN, DIV, PER_IN, CCR_IN, CCR_WR,
        input  TCR, CCR, E, TICK, PEND
    );

    modport slave (
        input  EN, DIV, PER_IN, CCR_IN, CCR_WR,
        output TCR, CCR, E, TICK, PEND
    );

endinterface

// File: rtl/pwm_prescaler.sv
// Prescaler: one count step every div+1 enabled clocks; step is the same-cycle
// decode, tick is its registered copy for the outside world.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             step,
    output logic             tick
);

    logic [DIV_W-1:0] psc;

    // >= rather than == so a lowered div mid-count steps at once instead of wrapping the counter.
    assign step = en && (psc >= div);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            psc  <= '0;
            tick <= TICK_RST;
        end else begin
            tick <= step;
            if (en) begin
                if (step) begin
                    psc <= '0;
                end else begin
                    psc <= psc + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled up-counter with wrap-time period reload and a
// shadowed compare register that only updates on the period boundary.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    pwm_timebase_if.slave bus
);

    logic             step;
    logic             tick_q;
    logic             wrap;
    logic [CNT_W-1:0] tcr_q;
    logic [CNT_W-1:0] per_act_q;
    logic [CNT_W-1:0] ccr_q;
    logic [CNT_W-1:0] shadow_q;
    logic             pend_q;

    pwm_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (bus.EN),
        .div   (bus.DIV),
        .step  (step),
        .tick  (tick_q)
    );

    assign wrap = step && (tcr_q == per_act_q);

    // The period is only re-read at wrap so a shorter request can never strand TCR above it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tcr_q     <= '0;
            per_act_q <= bus.PER_IN;
        end else if (step) begin
            if (wrap) begin
                tcr_q     <= '0;
                per_act_q <= bus.PER_IN;
            end else begin
                tcr_q <= tcr_q + 1'b1;
            end
        end
    end

    // A write landing exactly on the wrap goes straight to CCR so it is not deferred a full period.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ccr_q    <= '0;
            shadow_q <= '0;
            pend_q   <= PEND_RST;
        end else if (wrap) begin
            if (bus.CCR_WR) begin
                ccr_q    <= bus.CCR_IN;
                shadow_q <= bus.CCR_IN;
            end else if (pend_q) begin
                ccr_q <= shadow_q;
            end
            pend_q <= 1'b0;
        end else if (bus.CCR_WR) begin
            shadow_q <= bus.CCR_IN;
            pend_q   <= 1'b1;
        end
    end

    assign bus.TCR  = tcr_q;
    assign bus.CCR  = ccr_q;
    assign bus.E    = (tcr_q == '0);
    assign bus.TICK = tick_q;
    assign bus.PEND = pend_q;

endmodule
